// File: rtl/riscv_chk_pkg.sv
// Shared state and verdict encodings for the RISC-V result checker.
// Build option: define RISCV_CHK_STRICT_EN to fail runs that halt before the table is exhausted.
package riscv_chk_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL
    } state_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RUN        = 3'd1,
        ST_PASS       = 3'd2,
        ST_MISMATCH   = 3'd3,
        ST_SKIPPED    = 3'd4,
        ST_TIMEOUT    = 3'd5,
        ST_INCOMPLETE = 3'd6
    } status_e;

endpackage

// File: rtl/riscv_chk_table.sv
// Expected-result table: NUM_TEST entries of {num_inst, answer}.
// Synchronous write port and combinational read port. Contents are not reset.
module riscv_chk_table #(
    parameter int NUM_TEST = 23,
    parameter int IDX_W    = 5
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [31:0]      wr_num_i,
    input  logic [31:0]      wr_ans_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [31:0]      rd_num_o,
    output logic [31:0]      rd_ans_o
);

    localparam logic [IDX_W:0] NUM_W = (IDX_W+1)'(NUM_TEST);

    logic [63:0] mem_q [NUM_TEST];
    logic        wr_ok;
    logic        rd_ok;

    assign wr_ok = ({1'b0, wr_idx_i} < NUM_W);
    assign rd_ok = ({1'b0, rd_idx_i} < NUM_W);

    always_ff @(posedge clk_i) begin
        if (we_i && wr_ok) begin
            mem_q[wr_idx_i] <= {wr_num_i, wr_ans_i};
        end
    end

    always_comb begin
        rd_num_o = '0;
        rd_ans_o = '0;
        if (rd_ok) begin
            rd_num_o = mem_q[rd_idx_i][63:32];
            rd_ans_o = mem_q[rd_idx_i][31:0];
        end
    end

endmodule

// File: rtl/riscv_result_checker.sv
// Run monitor comparing core retirement outputs against a programmed checkpoint table.
// Build option: RISCV_CHK_STRICT_EN makes HALT before the last checkpoint a failure (STATUS 6).
module riscv_result_checker
    import riscv_chk_pkg::*;
#(
    parameter int NUM_TEST    = 23,
    parameter int IDX_W       = 5,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             TAB_WE,
    input  logic [IDX_W-1:0] TAB_IDX,
    input  logic [31:0]      TAB_NUM_INST,
    input  logic [31:0]      TAB_ANS,
    input  logic             START,
    input  logic [31:0]      NUM_INST,
    input  logic [31:0]      OUTPUT_PORT,
    input  logic             HALT,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [2:0]       STATUS,
    output logic [IDX_W-1:0] FAIL_IDX,
    output logic [31:0]      FAIL_GOT,
    output logic [IDX_W:0]   PASS_CNT,
    output logic [31:0]      CYCLE_CNT
);

    localparam logic [IDX_W:0] NUM_W        = (IDX_W+1)'(NUM_TEST);
    localparam logic [31:0]    TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);

    state_e           state_q, state_d;
    status_e          status_q, status_d;
    // Every checkpoint advance is a pass, so the pointer doubles as PASS_CNT.
    logic [IDX_W:0]   ptr_q, ptr_d;
    logic [31:0]      cyc_q, cyc_d;
    logic [IDX_W-1:0] fidx_q, fidx_d;
    logic [31:0]      fgot_q, fgot_d;

    logic        tab_we;
    logic [31:0] tab_num;
    logic [31:0] tab_ans;
    logic        start_run;
    logic        chk_fail;
    logic        incomplete;

    riscv_chk_table #(
        .NUM_TEST (NUM_TEST),
        .IDX_W    (IDX_W)
    ) u_table (
        .clk_i    (CLK),
        .we_i     (tab_we),
        .wr_idx_i (TAB_IDX),
        .wr_num_i (TAB_NUM_INST),
        .wr_ans_i (TAB_ANS),
        .rd_idx_i (ptr_q[IDX_W-1:0]),
        .rd_num_o (tab_num),
        .rd_ans_o (tab_ans)
    );

    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        ptr_d      = ptr_q;
        cyc_d      = cyc_q;
        fidx_d     = fidx_q;
        fgot_d     = fgot_q;
        tab_we     = 1'b0;
        start_run  = 1'b0;
        chk_fail   = 1'b0;
        incomplete = 1'b0;

        case (state_q)
            S_IDLE: begin
                tab_we    = TAB_WE & ~RST;
                start_run = START;
            end
            S_RUN: begin
                cyc_d = (cyc_q == '1) ? cyc_q : cyc_q + 32'd1;
                if (ptr_q < NUM_W) begin
                    if (NUM_INST == tab_num) begin
                        if (OUTPUT_PORT == tab_ans) begin
                            ptr_d = ptr_q + 1'b1;
                        end else begin
                            chk_fail = 1'b1;
                            status_d = ST_MISMATCH;
                            fidx_d   = ptr_q[IDX_W-1:0];
                            fgot_d   = OUTPUT_PORT;
                        end
                    end else if (NUM_INST > tab_num) begin
                        chk_fail = 1'b1;
                        status_d = ST_SKIPPED;
                        fidx_d   = ptr_q[IDX_W-1:0];
                    end
                end
`ifdef RISCV_CHK_STRICT_EN
                incomplete = (ptr_d < NUM_W);
`else
                incomplete = 1'b0;
`endif
                // Priority: check failure, then HALT verdict, then timeout.
                if (chk_fail) begin
                    state_d = S_FAIL;
                end else if (HALT) begin
                    if (incomplete) begin
                        state_d  = S_FAIL;
                        status_d = ST_INCOMPLETE;
                        fidx_d   = ptr_d[IDX_W-1:0];
                    end else begin
                        state_d  = S_PASS;
                        status_d = ST_PASS;
                    end
                end else if (cyc_q >= TIMEOUT_LAST) begin
                    state_d  = S_FAIL;
                    status_d = ST_TIMEOUT;
                end
            end
            S_PASS, S_FAIL: begin
                start_run = START;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (start_run) begin
            state_d  = S_RUN;
            status_d = ST_RUN;
            ptr_d    = '0;
            cyc_d    = '0;
            fidx_d   = '0;
            fgot_d   = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            status_q <= ST_IDLE;
            ptr_q    <= '0;
            cyc_q    <= '0;
            fidx_q   <= '0;
            fgot_q   <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            ptr_q    <= ptr_d;
            cyc_q    <= cyc_d;
            fidx_q   <= fidx_d;
            fgot_q   <= fgot_d;
        end
    end

    assign BUSY      = (state_q == S_RUN);
    assign DONE      = (state_q == S_PASS) || (state_q == S_FAIL);
    assign PASS      = (state_q == S_PASS);
    assign STATUS    = status_q;
    assign FAIL_IDX  = fidx_q;
    assign FAIL_GOT  = fgot_q;
    assign PASS_CNT  = ptr_q;
    assign CYCLE_CNT = cyc_q;

endmodule

// File: tb/tb_riscv_result_checker.sv
// Directed bench for riscv_result_checker with a run-replay reference model and per-cycle compare.
// Honours RISCV_CHK_STRICT_EN when defined for the build.
module tb_riscv_result_checker;

    localparam int NT = 3;
    localparam int IW = 2;
    localparam int TO = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          TAB_WE;
    logic [IW-1:0] TAB_IDX;
    logic [31:0]   TAB_NUM_INST;
    logic [31:0]   TAB_ANS;
    logic          START;
    logic [31:0]   NUM_INST;
    logic [31:0]   OUTPUT_PORT;
    logic          HALT;
    logic          BUSY;
    logic          DONE;
    logic          PASS;
    logic [2:0]    STATUS;
    logic [IW-1:0] FAIL_IDX;
    logic [31:0]   FAIL_GOT;
    logic [IW:0]   PASS_CNT;
    logic [31:0]   CYCLE_CNT;

    riscv_result_checker #(
        .NUM_TEST    (NT),
        .IDX_W       (IW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .TAB_WE       (TAB_WE),
        .TAB_IDX      (TAB_IDX),
        .TAB_NUM_INST (TAB_NUM_INST),
        .TAB_ANS      (TAB_ANS),
        .START        (START),
        .NUM_INST     (NUM_INST),
        .OUTPUT_PORT  (OUTPUT_PORT),
        .HALT         (HALT),
        .BUSY         (BUSY),
        .DONE         (DONE),
        .PASS         (PASS),
        .STATUS       (STATUS),
        .FAIL_IDX     (FAIL_IDX),
        .FAIL_GOT     (FAIL_GOT),
        .PASS_CNT     (PASS_CNT),
        .CYCLE_CNT    (CYCLE_CNT)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: the whole current run is logged and replayed from its first cycle.
    typedef struct {
        logic [31:0] num;
        logic [31:0] out;
        logic        halt;
    } samp_t;

    typedef struct {
        int          st;
        int          fi;
        int          pc;
        logic [31:0] fg;
    } verdict_t;

    logic [31:0] m_num [NT];
    logic [31:0] m_ans [NT];
    samp_t       run_log [$];

    int          e_status = 0;
    int          e_fidx   = 0;
    int          e_pcnt   = 0;
    int          e_cyc    = 0;
    logic [31:0] e_fgot   = '0;

    function automatic verdict_t replay();
        verdict_t v;
        samp_t    s;
        v.st = 1;
        v.fi = 0;
        v.pc = 0;
        v.fg = '0;
        for (int i = 0; i < run_log.size(); i++) begin
            if (v.st != 1) break;
            s = run_log[i];
            if (v.pc < NT && s.num == m_num[v.pc] && s.out != m_ans[v.pc]) begin
                v.st = 3;
                v.fi = v.pc;
                v.fg = s.out;
            end else if (v.pc < NT && s.num > m_num[v.pc]) begin
                v.st = 4;
                v.fi = v.pc;
            end else begin
                if (v.pc < NT && s.num == m_num[v.pc]) v.pc++;
                if (s.halt) begin
`ifdef RISCV_CHK_STRICT_EN
                    if (v.pc < NT) begin
                        v.st = 6;
                        v.fi = v.pc;
                    end else begin
                        v.st = 2;
                    end
`else
                    v.st = 2;
`endif
                end else if (i + 1 == TO) begin
                    v.st = 5;
                end
            end
        end
        return v;
    endfunction

    always @(posedge CLK) begin
        verdict_t v;
        if (RST) begin
            run_log.delete();
            e_status <= 0;
            e_fidx   <= 0;
            e_fgot   <= '0;
            e_pcnt   <= 0;
            e_cyc    <= 0;
        end else if (e_status == 1) begin
            run_log.push_back('{NUM_INST, OUTPUT_PORT, HALT});
            v = replay();
            e_status <= v.st;
            e_fidx   <= v.fi;
            e_fgot   <= v.fg;
            e_pcnt   <= v.pc;
            e_cyc    <= run_log.size();
        end else begin
            if (e_status == 0 && TAB_WE && int'(TAB_IDX) < NT) begin
                m_num[TAB_IDX] <= TAB_NUM_INST;
                m_ans[TAB_IDX] <= TAB_ANS;
            end
            if (START) begin
                run_log.delete();
                e_status <= 1;
                e_fidx   <= 0;
                e_fgot   <= '0;
                e_pcnt   <= 0;
                e_cyc    <= 0;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("BUSY",      32'(BUSY),      32'(e_status == 1));
            check("DONE",      32'(DONE),      32'(e_status >= 2));
            check("PASS",      32'(PASS),      32'(e_status == 2));
            check("STATUS",    32'(STATUS),    32'(e_status));
            check("FAIL_IDX",  32'(FAIL_IDX),  32'(e_fidx));
            check("FAIL_GOT",  FAIL_GOT,       e_fgot);
            check("PASS_CNT",  32'(PASS_CNT),  32'(e_pcnt));
            check("CYCLE_CNT", CYCLE_CNT,      32'(e_cyc));
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic load(input int idx, input int num, input int ans);
        TAB_WE       = 1'b1;
        TAB_IDX      = IW'(idx);
        TAB_NUM_INST = 32'(num);
        TAB_ANS      = 32'(ans);
        tick();
        TAB_WE       = 1'b0;
    endtask

    task automatic start_run();
        HALT     = 1'b0;
        NUM_INST = '0;
        START    = 1'b1;
        tick();
        START    = 1'b0;
    endtask

    task automatic step(input int num, input int out, input bit halt);
        NUM_INST    = 32'(num);
        OUTPUT_PORT = 32'(out);
        HALT        = halt;
        tick();
        HALT        = 1'b0;
    endtask

    task automatic basic_pass_run();
        start_run();
        step(1, 0, 0);
        step(2, 0, 0);
        step(3, 5, 1);
        check("lit_pass_PASS",     32'(PASS),     32'd1);
        check("lit_pass_STATUS",   32'(STATUS),   32'd2);
        check("lit_pass_PASS_CNT", 32'(PASS_CNT), 32'd3);
    endtask

    initial begin
        RST = 1'b1; TAB_WE = 1'b0; TAB_IDX = '0; TAB_NUM_INST = '0; TAB_ANS = '0;
        START = 1'b0; NUM_INST = '0; OUTPUT_PORT = '0; HALT = 1'b0;
        tick();
        tick();
        chk_en = 1'b1;
        check("lit_rst_STATUS", 32'(STATUS), 32'd0);
        check("lit_rst_DONE",   32'(DONE),   32'd0);
        RST = 1'b0;
        tick();

        load(0, 1, 0);
        load(1, 2, 0);
        load(2, 3, 5);
        load(3, 9, 9);

        basic_pass_run();
        step(4, 0, 0);
        check("lit_hold_STATUS", 32'(STATUS), 32'd2);

        start_run();
        step(1, 0, 0);
        step(2, 0, 0);
        step(3, 4, 0);
        check("lit_mm_STATUS",   32'(STATUS),   32'd3);
        check("lit_mm_FAIL_IDX", 32'(FAIL_IDX), 32'd2);
        check("lit_mm_FAIL_GOT", FAIL_GOT,      32'd4);
        check("lit_mm_PASS_CNT", 32'(PASS_CNT), 32'd2);
        check("lit_mm_DONE",     32'(DONE),     32'd1);

        start_run();
        step(1, 0, 0);
        step(3, 5, 0);
        check("lit_skip_STATUS",   32'(STATUS),   32'd4);
        check("lit_skip_FAIL_IDX", 32'(FAIL_IDX), 32'd1);

        start_run();
        for (int i = 0; i < TO + 4 && !DONE; i++) begin
            step(0, 0, 0);
            if (i == TO - 2) check("lit_to_pre_STATUS", 32'(STATUS), 32'd1);
        end
        check("lit_to_STATUS",    32'(STATUS),    32'd5);
        check("lit_to_CYCLE_CNT", CYCLE_CNT,      32'd16);

        start_run();
        step(1, 7, 1);
        check("lit_halt_mm_STATUS",   32'(STATUS),   32'd3);
        check("lit_halt_mm_FAIL_GOT", FAIL_GOT,      32'd7);

        start_run();
        step(1, 0, 1);
`ifdef RISCV_CHK_STRICT_EN
        check("lit_strict_STATUS",   32'(STATUS),   32'd6);
        check("lit_strict_FAIL_IDX", 32'(FAIL_IDX), 32'd1);
`else
        check("lit_early_STATUS",   32'(STATUS),   32'd2);
        check("lit_early_PASS_CNT", 32'(PASS_CNT), 32'd1);
`endif

        // START and a table write are both ignored mid-run; reset then aborts the run.
        start_run();
        for (int i = 0; i < 7; i++) begin
            if (i == 2) START = 1'b1;
            if (i == 3) begin
                TAB_WE = 1'b1; TAB_IDX = 2'd2; TAB_NUM_INST = 32'd3; TAB_ANS = 32'd9;
            end
            step(0, 0, 0);
            START  = 1'b0;
            TAB_WE = 1'b0;
        end
        check("lit_rst_mid_CYCLE_CNT", CYCLE_CNT, 32'd7);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("lit_abort_BUSY",      32'(BUSY),      32'd0);
        check("lit_abort_STATUS",    32'(STATUS),    32'd0);
        check("lit_abort_CYCLE_CNT", CYCLE_CNT,      32'd0);
        check("lit_abort_PASS_CNT",  32'(PASS_CNT),  32'd0);

        basic_pass_run();

        RST = 1'b1;
        tick();
        RST = 1'b0;
        load(0, 5, 1);
        load(1, 5, 2);
        load(2, 6, 3);
        start_run();
        step(5, 1, 0);
        step(5, 2, 0);
        step(6, 3, 1);
        check("lit_same_STATUS",   32'(STATUS),   32'd2);
        check("lit_same_PASS_CNT", 32'(PASS_CNT), 32'd3);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
